// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - load/store sequencer between MEM stage and data-memory bus
// Optional: LSU_MISALIGN_TRAP_EN faults split accesses instead of issuing two word transactions.
module lsu_ctrl #(
    parameter int AW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    input  logic          req_load,
    input  logic          req_store,
    input  logic [2:0]    funct3,
    input  logic [AW-1:0] req_addr,
    input  logic [31:0]   req_wdata,
    output logic          stall,
    output logic          done,
    output logic [31:0]   ld_data,
    output logic          misalign_fault,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [3:0]    mem_wstrb,
    output logic [31:0]   mem_wdata,
    input  logic          mem_gnt,
    input  logic          mem_rvalid,
    input  logic [31:0]   mem_rdata
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_REQ0  = 3'd1;
    localparam logic [2:0] S_WAIT0 = 3'd2;
    localparam logic [2:0] S_REQ1  = 3'd3;
    localparam logic [2:0] S_WAIT1 = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    logic [2:0]    state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [2:0]    f3_q, f3_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   word0_q, word0_d;
    logic [23:0]   word1_q, word1_d;
    logic          load_q, load_d;
    logic          fault_q, fault_d;

    function automatic logic [2:0] size_of(input logic [2:0] f3);
        case (f3)
            3'd0, 3'd4: size_of = 3'd1;
            3'd1, 3'd5: size_of = 3'd2;
            default:    size_of = 3'd4;
        endcase
    endfunction

    logic          active;
    logic          in_split;
    logic [2:0]    q_size;
    logic [1:0]    q_off;
    logic          q_split;
    logic [3:0]    mask4;
    logic [7:0]    strb8;
    logic [63:0]   data64;
    logic [AW-1:0] base_addr;
    logic [31:0]   ld_shift;

    assign active   = req_valid & (req_load | req_store);
    assign in_split = ({1'b0, req_addr[1:0]} + size_of(funct3)) > 3'd4;
    assign q_size   = size_of(f3_q);
    assign q_off    = addr_q[1:0];
    assign q_split  = ({1'b0, q_off} + q_size) > 3'd4;
    assign mask4    = (q_size == 3'd1) ? 4'b0001 : (q_size == 3'd2) ? 4'b0011 : 4'b1111;
    assign strb8    = {4'b0000, mask4} << q_off;
    assign data64   = {32'h0, wdata_q} << {q_off, 3'b000};
    assign base_addr = {addr_q[AW-1:2], 2'b00};

    // Right-justify the byte at addr; word1 only contributes bytes that crossed the word boundary.
    always_comb begin
        ld_shift = word0_q;
        case (q_off)
            2'd1:    ld_shift = {word1_q[7:0],  word0_q[31:8]};
            2'd2:    ld_shift = {word1_q[15:0], word0_q[31:16]};
            2'd3:    ld_shift = {word1_q[23:0], word0_q[31:24]};
            default: ld_shift = word0_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        f3_d    = f3_q;
        wdata_d = wdata_q;
        word0_d = word0_q;
        word1_d = word1_q;
        load_d  = load_q;
        fault_d = fault_q;
        case (state_q)
            S_IDLE: begin
                if (active) begin
                    addr_d  = req_addr;
                    f3_d    = funct3;
                    wdata_d = req_wdata;
                    load_d  = req_load;
                    word0_d = '0;
                    word1_d = '0;
                    fault_d = 1'b0;
                    state_d = S_REQ0;
`ifdef LSU_MISALIGN_TRAP_EN
                    if (in_split) begin
                        fault_d = 1'b1;
                        state_d = S_DONE;
                    end
`else
                    if (in_split) begin
                        state_d = S_REQ0;
                    end
`endif
                end
            end
            S_REQ0: begin
                if (mem_gnt) begin
                    if (load_q)       state_d = S_WAIT0;
                    else if (q_split) state_d = S_REQ1;
                    else              state_d = S_DONE;
                end
            end
            S_WAIT0: begin
                if (mem_rvalid) begin
                    word0_d = mem_rdata;
                    state_d = q_split ? S_REQ1 : S_DONE;
                end
            end
            S_REQ1: begin
                if (mem_gnt) state_d = load_q ? S_WAIT1 : S_DONE;
            end
            S_WAIT1: begin
                if (mem_rvalid) begin
                    word1_d = mem_rdata[23:0];
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            f3_q    <= '0;
            wdata_q <= '0;
            word0_q <= '0;
            word1_q <= '0;
            load_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            f3_q    <= f3_d;
            wdata_q <= wdata_d;
            word0_q <= word0_d;
            word1_q <= word1_d;
            load_q  <= load_d;
            fault_q <= fault_d;
        end
    end

    // stall is gated by rst_n so every output reads 0 while reset is held.
    assign done    = (state_q == S_DONE);
    assign stall   = rst_n & active & ~done;
    assign ld_data = (done & ~fault_q) ? ld_shift : 32'h0;
    assign mem_req = (state_q == S_REQ0) | (state_q == S_REQ1);
    assign mem_we  = mem_req & ~load_q;
    assign mem_addr  = (state_q == S_REQ0) ? base_addr :
                       (state_q == S_REQ1) ? base_addr + AW'(4) : '0;
    assign mem_wstrb = ~mem_we ? 4'b0000 :
                       (state_q == S_REQ1) ? strb8[7:4] : strb8[3:0];
    assign mem_wdata = ~mem_we ? 32'h0 :
                       (state_q == S_REQ1) ? data64[63:32] : data64[31:0];

`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign_fault = done & fault_q;
`else
    assign misalign_fault = 1'b0;
`endif

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store sequencer between the MEM stage and the data-memory bus.
- Issues req/gnt/rvalid bus transactions and stalls the pipeline while an access is in flight.
- Splits misaligned accesses into two word transactions.
- Returns the loaded bytes right-justified (byte at addr in bits [7:0]) to the writeback stage, which performs sign/zero extension by funct3.

Parameters:
- AW, 32, address width of req_addr and mem_addr.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  MEM stage holds a valid instruction
- req_load  in  1  instruction is a load
- req_store  in  1  instruction is a store
- funct3  in  3  size: 0/4 byte, 1/5 half, 2 word; 3/6/7 treated as word
- req_addr  in  AW  byte address
- req_wdata  in  32  store data, right-justified
- stall  out  1  freeze the pipeline
- done  out  1  one-cycle pulse: access complete
- ld_data  out  32  right-justified load bytes, valid while done=1
- misalign_fault  out  1  one-cycle fault pulse (optional feature only)
- mem_req  out  1  bus request
- mem_we  out  1  write enable
- mem_addr  out  AW  word-aligned address (bits [1:0]=0)
- mem_wstrb  out  4  byte strobes
- mem_wdata  out  32  lane-aligned write data
- mem_gnt  in  1  request accepted this cycle
- mem_rvalid  in  1  read data valid
- mem_rdata  in  32  read data word

Behaviour:
- Reset: asynchronous, active-low. All outputs 0; FSM to IDLE; internal data registers cleared. Reset mid-transaction abandons the access, and no done pulse follows.
- Definitions:
  - active = req_valid & (req_load | req_store)
  - size = 1, 2 or 4 bytes from funct3
  - off = req_addr[1:0]
  - split = (off + size) > 4
- stall = active & ~done, combinational. The pipeline advances on the clock edge where done=1.
- FSM states: IDLE, REQ0, WAIT0, REQ1, WAIT1, DONE.
  - IDLE: if active, capture addr/funct3/wdata/type and go to REQ0. req_load and req_store both high is treated as a load.
  - REQ0: mem_req=1, mem_addr={addr[AW-1:2],2'b00}. Held with all bus outputs stable until mem_gnt. On gnt: store & ~split -> DONE; store & split -> REQ1; load -> WAIT0.
  - WAIT0: on mem_rvalid, latch word0; then ~split -> DONE, split -> REQ1. mem_rvalid may arrive no earlier than the cycle after gnt.
  - REQ1: mem_addr = word0 address + 4, wrapping modulo 2^AW. Held until gnt: store -> DONE, load -> WAIT1.
  - WAIT1: on mem_rvalid, latch word1 -> DONE.
  - DONE: done=1 for exactly one cycle, ld_data valid; next state IDLE. A new request is accepted no earlier than the following cycle, so there is a minimum one idle cycle between accesses.
- Best-case latency: aligned store = 2 cycles request-to-done; aligned load with rvalid one cycle after gnt = 3 cycles.
- Store lanes:
  - mask = (1<<size)-1
  - strobe64 = mask << off; data64 = req_wdata << (8*off)
  - First access uses the low 32 bits of strobe64/data64; second access uses the high 32 bits.
- Loads: ld_data = ({word1,word0} >> (8*off))[31:0]. word1 = 0 when not split. Bytes above size are don't-care; writeback masks them.
- mem_rvalid in IDLE, REQ0, REQ1 or DONE is ignored.
- mem_we=0 and mem_wstrb=0 for loads.
- All bus outputs are 0 outside REQ0/REQ1.

Optional Feature:
- LSU_MISALIGN_TRAP_EN defined:
  - A split access makes no bus transaction. IDLE -> DONE directly, with misalign_fault=1 and done=1 in the same cycle; ld_data=0.
  - REQ1 and WAIT1 are unreachable.
- Undefined: misalign_fault is tied to 0 and the split behaviour above applies.

Test Plan:
- Aligned lw addr 0x100, gnt immediately, rvalid next cycle with 0xDEADBEEF -> mem_addr=0x100, we=0; done on cycle 3 with ld_data=0xDEADBEEF; stall high on cycles 1-2.
- sb addr 0x203, wdata 0x000000A5 -> single write to 0x200, wstrb=4'b1000, wdata=0xA5000000; done 2 cycles after request.
- lw addr 0x302; rdata 0x44332211 from 0x300 then 0x88776655 from 0x304 -> two reads; ld_data=0x66554433.
- sw addr 0x401, wdata 0xAABBCCDD -> write 0x400 wstrb 4'b1110 wdata 0xBBCCDD00, then 0x404 wstrb 4'b0001 wdata 0x000000AA.
- lh addr 0x10, gnt held low 3 cycles, then rvalid -> mem_req and mem_addr stable throughout; done only after rvalid. Assert rst_n low during WAIT0 -> all outputs 0, no done; a later stray rvalid is ignored.
- With LSU_MISALIGN_TRAP_EN: lw addr 0x302 -> no mem_req; done and misalign_fault both high on the cycle after request.
